// File: rtl/key_bank.sv
// key_bank: two-slot (even/odd) store for expanded block-cipher key schedules.
// A schedule is captured on key_schedule's done pulse and later streamed out
// one round-key byte per beat, from byte NBYTES-1 down to byte 0.
//
// Output handshake: kb_valid/kb_byte/kb_round/kb_last form a valid/ready
// source. Once kb_valid is high it stays high, and every payload field holds
// its value, until a cycle with kb_ready=1. A beat moves on the rising edge
// where kb_valid & kb_ready. There are never bubbles inside a stream.
module key_bank #(
  parameter int NBYTES = 56,
  parameter int BW     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ks_done,
  input  logic [NBYTES*BW-1:0] ks_kk,
  input  logic                 ks_sel,
  input  logic [1:0]           key_clr,
  input  logic                 rd_req,
  input  logic                 rd_sel,
  input  logic                 kb_ready,
  output logic                 kb_valid,
  output logic [BW-1:0]        kb_byte,
  output logic [5:0]           kb_round,
  output logic                 kb_last,
  output logic                 rd_busy,
  output logic                 rd_err,
  output logic [1:0]           slot_vld
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [5:0] LAST_ROUND = 6'(NBYTES - 1);

  state_t                     state;
  logic                       act_sel;
  logic [5:0]                 round_q;
  logic                       rd_err_q;
  logic [1:0]                 vld_q;
  logic [1:0]                 vld_next;
  logic [NBYTES-1:0][BW-1:0]  slot_mem [2];
  logic [NBYTES-1:0][BW-1:0]  pend_data;
  logic                       pend_vld;
  logic                       pend_sel;
  logic [5:0]                 rd_idx;

  logic streaming;
  logic xfer;
  logic last_xfer;
  logic conflict;
  logic direct_wr;
  logic commit;

  assign streaming = (state == STREAM);
  assign xfer      = streaming && kb_ready;
  assign last_xfer = xfer && (round_q == LAST_ROUND);
  // A capture aimed at the slot being streamed is parked, except on the final
  // beat: the stream ends at that edge, so the slot can be written directly.
  assign conflict  = ks_done && streaming && (ks_sel == act_sel) && !last_xfer;
  assign direct_wr = ks_done && !conflict;
  assign commit    = last_xfer && pend_vld;

  // Stream control FSM: slot selection, beat counter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      act_sel  <= 1'b0;
      round_q  <= '0;
      rd_err_q <= 1'b0;
    end else begin
      rd_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            if (vld_q[rd_sel]) begin
              state   <= STREAM;
              act_sel <= rd_sel;
              round_q <= '0;
            end else begin
              rd_err_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (round_q == LAST_ROUND) begin
              state   <= IDLE;
              round_q <= '0;
            end else begin
              round_q <= round_q + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next slot-valid flags: clears first, then captures/commits override them.
  always_comb begin
    vld_next = vld_q & ~key_clr;
    if (commit)    vld_next[pend_sel] = 1'b1;
    if (direct_wr) vld_next[ks_sel]   = 1'b1;
  end

  // Slot-valid flags and pending-capture tag; reset drops any parked capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      pend_vld <= 1'b0;
      pend_sel <= 1'b0;
    end else begin
      vld_q <= vld_next;
      if (conflict) begin
        pend_vld <= 1'b1;
        pend_sel <= ks_sel;
      end else if (commit) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Key storage: no reset needed, contents are qualified by the valid flags.
  // A direct write after the commit wins when both target the same slot.
  always_ff @(posedge clk) begin
    if (conflict)  pend_data          <= ks_kk;
    if (commit)    slot_mem[pend_sel] <= pend_data;
    if (direct_wr) slot_mem[ks_sel]   <= ks_kk;
  end

  // Beat 0 carries the highest byte; the streamed slot is never written mid-stream.
  assign rd_idx   = LAST_ROUND - round_q;
  assign kb_valid = streaming;
  assign rd_busy  = streaming;
  assign kb_round = round_q;
  assign kb_last  = streaming && (round_q == LAST_ROUND);
  assign kb_byte  = streaming ? slot_mem[act_sel][rd_idx] : '0;
  assign rd_err   = rd_err_q;
  assign slot_vld = vld_q;

endmodule
